// File: rtl/mem_stage_pkg.sv
// Shared encodings and defaults for the memory access stage.
package mem_stage_pkg;

    localparam int DEFAULT_DEPTH   = 2048;
    localparam int DEFAULT_SP_INIT = 2047;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10
    } sp_op_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/data_mem.sv
// DEPTH x 16 data array with synchronous write and a registered read port.
module data_mem #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_d;
    logic [15:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // The array itself is never cleared; a reset edge only suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: owns SP and data memory, stalls upstream for MEM_LAT cycles per access.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = 11,
    parameter int SP_INIT = DEFAULT_SP_INIT,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite,
    input  logic        MemOrReg,
    input  logic        DestOrPrivate,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        SPOrALUres,
    input  logic [1:0]  SPOpeartion,
    input  logic [3:0]  regDestAddress,
    input  logic [15:0] ALUResult,
    input  logic [15:0] RegSrc,
    output logic        stall,
    output logic        oRegWrite,
    output logic        oMemOrReg,
    output logic        oDestOrPrivate,
    output logic [3:0]  oRegDestAddress,
    output logic [15:0] oALUResult,
    output logic [15:0] oMemData,
    output logic [15:0] oSP,
    output logic        stack_fault
);

    localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic [1:0]    spop_q, spop_d;
    logic [AW-1:0] sp_q, sp_d;
    logic          fault_q, fault_d;

    logic          mem_op;
    logic [AW-1:0] sel_addr;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          retire;
    logic [1:0]    retire_op;

    assign mem_op   = MemRead | MemWrite;
    assign sel_addr = !SPOrALUres            ? ALUResult[AW-1:0] :
                      (SPOpeartion == SP_POP) ? sp_q + AW'(1)     : sp_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        re_d      = re_q;
        spop_d    = spop_q;
        stall     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        retire    = 1'b0;
        retire_op = SPOpeartion;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall   = 1'b1;
                    addr_d  = sel_addr;
                    wdata_d = RegSrc;
                    we_d    = MemWrite;
                    re_d    = MemRead & ~MemWrite;
                    spop_d  = SPOpeartion;
                    // Single-cycle memory: access straight from the live inputs.
                    if (MEM_LAT == 1) begin
                        mem_we    = MemWrite;
                        mem_re    = MemRead & ~MemWrite;
                        mem_addr  = sel_addr;
                        mem_wdata = RegSrc;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
                        state_d = WAIT;
                    end
                end else begin
                    retire = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    mem_we  = we_q;
                    mem_re  = re_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                retire    = 1'b1;
                retire_op = spop_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // SP moves only on the retiring edge; wrap is legal but flagged.
    always_comb begin
        sp_d    = sp_q;
        fault_d = 1'b0;
        if (retire) begin
            if (retire_op == SP_PUSH) begin
                sp_d    = sp_q - AW'(1);
                fault_d = (sp_q == '0);
            end else if (retire_op == SP_POP) begin
                sp_d    = sp_q + AW'(1);
                fault_d = (sp_q == AW'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            spop_q  <= SP_NONE;
            sp_q    <= AW'(SP_INIT);
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            spop_q  <= spop_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    data_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_data_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(oMemData)
    );

    assign oRegWrite       = RegWrite & ~stall;
    assign oMemOrReg       = MemOrReg;
    assign oDestOrPrivate  = DestOrPrivate;
    assign oRegDestAddress = regDestAddress;
    assign oALUResult      = ALUResult;
    assign oSP             = {{(16 - AW){1'b0}}, sp_q};
    assign stack_fault     = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: one instance with MEM_LAT=1, one with MEM_LAT=3,
// both compared against a transaction-level memory/stack model.
module tb_mem_access_stage;

    typedef struct packed {
        logic        RegWrite;
        logic        MemOrReg;
        logic        DestOrPrivate;
        logic        MemWrite;
        logic        MemRead;
        logic        SPOrALUres;
        logic [1:0]  spop;
        logic [3:0]  dest;
        logic [15:0] alu;
        logic [15:0] src;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        regWrite;
        logic        memOrReg;
        logic        destOrPrivate;
        logic [3:0]  dest;
        logic [15:0] alu;
        logic [15:0] memData;
        logic [15:0] sp;
        logic        fault;
    } out_t;

    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    in_t  di0, di1;
    out_t ob0, ob1;

    logic        st0, rw0, mr0, dp0, sf0;
    logic [3:0]  da0;
    logic [15:0] al0, md0, sp0;
    logic        st1, rw1, mr1, dp1, sf1;
    logic [3:0]  da1;
    logic [15:0] al1, md1, sp1;

    assign ob0 = {st0, rw0, mr0, dp0, da0, al0, md0, sp0, sf0};
    assign ob1 = {st1, rw1, mr1, dp1, da1, al1, md1, sp1, sf1};

    mem_access_stage #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst0),
        .RegWrite(di0.RegWrite), .MemOrReg(di0.MemOrReg), .DestOrPrivate(di0.DestOrPrivate),
        .MemWrite(di0.MemWrite), .MemRead(di0.MemRead), .SPOrALUres(di0.SPOrALUres),
        .SPOpeartion(di0.spop), .regDestAddress(di0.dest), .ALUResult(di0.alu), .RegSrc(di0.src),
        .stall(st0), .oRegWrite(rw0), .oMemOrReg(mr0), .oDestOrPrivate(dp0),
        .oRegDestAddress(da0), .oALUResult(al0), .oMemData(md0), .oSP(sp0), .stack_fault(sf0)
    );

    mem_access_stage #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst1),
        .RegWrite(di1.RegWrite), .MemOrReg(di1.MemOrReg), .DestOrPrivate(di1.DestOrPrivate),
        .MemWrite(di1.MemWrite), .MemRead(di1.MemRead), .SPOrALUres(di1.SPOrALUres),
        .SPOpeartion(di1.spop), .regDestAddress(di1.dest), .ALUResult(di1.alu), .RegSrc(di1.src),
        .stall(st1), .oRegWrite(rw1), .oMemOrReg(mr1), .oDestOrPrivate(dp1),
        .oRegDestAddress(da1), .oALUResult(al1), .oMemData(md1), .oSP(sp1), .stack_fault(sf1)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Reference state: memory contents, which words are known, SP and last loaded word.
    logic [15:0] memModel   [2][DEPTH];
    bit          validModel [2][DEPTH];
    int          spModel    [2];
    logic [15:0] lastRead   [2];
    bit          lastKnown  [2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input in_t v);
        if (idx == 0) di0 = v;
        else          di1 = v;
    endtask

    task automatic getOut(input int idx, output out_t o);
        o = (idx == 0) ? ob0 : ob1;
    endtask

    function automatic in_t mk(bit rw, bit mw, bit mrd, bit sps, logic [1:0] spop,
                               logic [15:0] alu, logic [15:0] src);
        in_t v;
        v               = '0;
        v.RegWrite      = rw;
        v.MemWrite      = mw;
        v.MemRead       = mrd;
        v.SPOrALUres    = sps;
        v.spop          = spop;
        v.alu           = alu;
        v.src           = src;
        v.MemOrReg      = mrd;
        v.DestOrPrivate = src[0];
        v.dest          = alu[15:12];
        return v;
    endfunction

    function automatic in_t randOp();
        in_t         v;
        logic [15:0] alu;
        alu = {5'($urandom), 11'($urandom_range(0, 15))};
        case ($urandom_range(0, 6))
            0: v = mk(1'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, alu, 16'($urandom));
            1: v = mk(1'($urandom), 1'b0, 1'b1, 1'b0, 2'b00, alu, 16'($urandom));
            2: v = mk(1'($urandom), 1'b1, 1'b0, 1'b1, 2'b01, alu, 16'($urandom));
            3: v = mk(1'($urandom), 1'b0, 1'b1, 1'b1, 2'b10, alu, 16'($urandom));
            4: v = mk(1'($urandom), 1'b0, 1'b0, 1'($urandom), 2'($urandom), alu, 16'($urandom));
            5: v = mk(1'($urandom), 1'b1, 1'b1, 1'b0, 2'b00, alu, 16'($urandom));
            default: v = mk(1'($urandom), 1'b0, 1'b1, 1'b1, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11,
                            alu, 16'($urandom));
        endcase
        v.DestOrPrivate = 1'($urandom);
        return v;
    endfunction

    // Drive one transaction, hold it through the stall, then check retirement and SP/fault.
    task automatic runOp(input int idx, input in_t v);
        out_t o;
        int   stalls   = 0;
        int   lat      = (idx == 0) ? 1 : 3;
        bit   memop    = v.MemRead | v.MemWrite;
        int   sp       = spModel[idx];
        int   a;
        bit   expFault;
        if (v.SPOrALUres) a = (v.spop == 2'b10) ? (sp + 1) % DEPTH : sp;
        else              a = int'(v.alu[10:0]);
        @(negedge clk);
        applyStimulus(idx, v);
        #1;
        getOut(idx, o);
        while (o.stall && stalls < 20) begin
            checkOutput("regwrite_while_stalled", 32'(o.regWrite), 32'd0);
            stalls++;
            @(negedge clk);
            #1;
            getOut(idx, o);
        end
        checkOutput("stall_cycles", 32'(stalls), memop ? 32'(lat) : 32'd0);
        checkOutput("oRegWrite", 32'(o.regWrite), 32'(v.RegWrite));
        checkOutput("passthrough", 32'({o.memOrReg, o.destOrPrivate, o.dest, o.alu}),
                    32'({v.MemOrReg, v.DestOrPrivate, v.dest, v.alu}));
        if (v.MemWrite) begin
            memModel[idx][a]   = v.src;
            validModel[idx][a] = 1'b1;
        end else if (v.MemRead) begin
            lastRead[idx]  = memModel[idx][a];
            lastKnown[idx] = validModel[idx][a];
        end
        if (lastKnown[idx]) checkOutput("oMemData", 32'(o.memData), 32'(lastRead[idx]));
        expFault = (v.spop == 2'b01 && sp == 0) || (v.spop == 2'b10 && sp == DEPTH - 1);
        if (v.spop == 2'b01)      spModel[idx] = (sp + DEPTH - 1) % DEPTH;
        else if (v.spop == 2'b10) spModel[idx] = (sp + 1) % DEPTH;
        @(posedge clk);
        #1;
        getOut(idx, o);
        checkOutput("oSP", 32'(o.sp), 32'(spModel[idx]));
        checkOutput("stack_fault", 32'(o.fault), 32'(expFault));
        applyStimulus(idx, '0);
    endtask

    task automatic modelReset(input int idx);
        spModel[idx]   = 2047;
        lastRead[idx]  = 16'h0000;
        lastKnown[idx] = 1'b1;
    endtask

    task automatic checkIdle(input int idx, input string tag);
        out_t o;
        getOut(idx, o);
        checkOutput({tag, "_stall"}, 32'(o.stall), 32'd0);
        checkOutput({tag, "_sp"}, 32'(o.sp), 32'd2047);
        checkOutput({tag, "_fault"}, 32'(o.fault), 32'd0);
    endtask

    initial begin
        out_t o;
        rst0 = 1'b0;
        rst1 = 1'b0;
        di0  = '0;
        di1  = '0;
        modelReset(0);
        modelReset(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle(0, "reset1");
        checkIdle(1, "reset3");
        checkOutput("reset1_memdata", 32'(md0), 32'd0);
        checkOutput("reset3_memdata", 32'(md1), 32'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;

        // MEM_LAT=1: store/load, push/pop, wrap boundaries, non-memory op.
        runOp(0, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd5, 16'hBEEF));
        runOp(0, mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'd5, 16'h0000));
        getOut(0, o);
        checkOutput("load_beef", 32'(o.memData), 32'h0000BEEF);
        runOp(0, mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'd0, 16'h1234));
        getOut(0, o);
        checkOutput("push_sp", 32'(o.sp), 32'd2046);
        runOp(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 16'd0, 16'h0000));
        getOut(0, o);
        checkOutput("pop_data", 32'(o.memData), 32'h00001234);
        checkOutput("pop_sp", 32'(o.sp), 32'd2047);
        runOp(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 16'd0, 16'h0000));
        getOut(0, o);
        checkOutput("pop_wrap_fault", 32'({o.fault, o.sp}), 32'h00010000);
        runOp(0, mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'd0, 16'h5A5A));
        getOut(0, o);
        checkOutput("push_wrap_fault", 32'({o.fault, o.sp}), 32'h000107FF);
        runOp(0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h00AA, 16'h0000));
        for (int a = 0; a < 16; a++) runOp(0, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'(a), 16'($urandom)));
        for (int n = 0; n < 150; n++) runOp(0, randOp());

        // MEM_LAT=3: latency, reset during WAIT of a store, then random traffic.
        for (int a = 0; a < 16; a++) runOp(1, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'(a), 16'($urandom)));
        runOp(1, mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'd9, 16'h0000));
        @(negedge clk);
        applyStimulus(1, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd9, 16'hDEAD));
        #1;
        checkOutput("midreset_stall_idle", 32'(st1), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("midreset_stall_wait", 32'(st1), 32'd1);
        rst1 = 1'b0;
        applyStimulus(1, '0);
        @(posedge clk);
        #1;
        checkIdle(1, "midreset");
        modelReset(1);
        @(negedge clk);
        rst1 = 1'b1;
        runOp(1, mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'd9, 16'h0000));
        for (int n = 0; n < 100; n++) runOp(1, randOp());

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
